// File: rtl/rope_electro_scheduler.sv
// -----------------------------------------------------------------------------
// rope_electro_scheduler
//
// Frame-rate controller for the electrified-rope hazard. One rope at a time is
// taken through IDLE -> WARN -> LIVE -> COOL, each phase lasting a fixed number
// of video frames. Ropes are chosen round-robin starting after the last rope
// used, skipping any rope the monkey is touching at the moment of selection.
// While a rope is live, the first contact with it raises a one-cycle shock
// pulse; further contact in the same live phase is ignored.
//
// Ports:
//   clk             system clock
//   resetN          asynchronous active-low reset
//   startOfFrame    one-cycle pulse per video frame; the only thing that
//                   advances the phase timer
//   enable          scheduler run enable; low forces IDLE and blanks outputs
//   monkeyCollision per-rope monkey contact (level)
//   electroStatus   per-rope status: 00 off, 01 warn, 10 live, 11 cool
//   activeRope      index of the selected rope (meaningful while busy)
//   busy            high in WARN / LIVE / COOL
//   shockHit        one-cycle pulse when the monkey touches the live rope
//
// All outputs are registered from the next-state values, so they change on
// the same edge that samples the causing startOfFrame / collision.
// -----------------------------------------------------------------------------
module rope_electro_scheduler #(
  parameter int ROPES       = 6,
  parameter int IDLE_FRAMES = 60,
  parameter int WARN_FRAMES = 30,
  parameter int LIVE_FRAMES = 45,
  parameter int COOL_FRAMES = 20,
  parameter int IDX_W       = $clog2(ROPES)
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic                       enable,
  input  logic [ROPES-1:0]           monkeyCollision,
  output logic [ROPES-1:0][1:0]      electroStatus,
  output logic [IDX_W-1:0]           activeRope,
  output logic                       busy,
  output logic                       shockHit
);

  // Frame counter sized for the longest phase.
  localparam int MAX_A  = (IDLE_FRAMES > WARN_FRAMES) ? IDLE_FRAMES : WARN_FRAMES;
  localparam int MAX_B  = (LIVE_FRAMES > COOL_FRAMES) ? LIVE_FRAMES : COOL_FRAMES;
  localparam int MAX_F  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W  = (MAX_F > 1) ? $clog2(MAX_F) : 1;

  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_FRAMES - 1);
  localparam logic [CNT_W-1:0] WARN_LOAD = CNT_W'(WARN_FRAMES - 1);
  localparam logic [CNT_W-1:0] LIVE_LOAD = CNT_W'(LIVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOL_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WARN = 2'd1,
    S_LIVE = 2'd2,
    S_COOL = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [IDX_W-1:0]        active_d;
  logic                    shock_done_q, shock_done_d;
  logic                    shock_d;
  logic                    busy_d;
  logic [ROPES-1:0][1:0]   status_d;

  // Round-robin candidate: first non-colliding rope after last_q, wrapping.
  // The sum needs one extra bit since last_q + ROPES can exceed ROPES-1.
  logic                    pick_found;
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W:0]          cand;

  // NOTE: every signal written in an always_comb gets a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= ROPES; i++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(ROPES)) begin
        cand = cand - (IDX_W+1)'(ROPES);
      end
      if (!pick_found && !monkeyCollision[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    active_d     = activeRope;
    shock_done_d = shock_done_q;
    shock_d      = 1'b0;

    if (!enable) begin
      // Disable overrides any coincident frame pulse or contact; lastRope and
      // activeRope are kept so rotation resumes where it stopped.
      state_d = S_IDLE;
      cnt_d   = IDLE_LOAD;
    end else begin
      // Shock is judged on the current state, so contact in the cycle that
      // leaves LIVE still counts.
      if (state_q == S_LIVE && monkeyCollision[activeRope] && !shock_done_q) begin
        shock_d      = 1'b1;
        shock_done_d = 1'b1;
      end

      if (startOfFrame) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          case (state_q)
            S_IDLE: begin
              // With every rope occupied the counter stays at zero, so the
              // selection is retried on the next frame.
              if (pick_found) begin
                state_d  = S_WARN;
                cnt_d    = WARN_LOAD;
                active_d = pick_idx;
                last_d   = pick_idx;
              end
            end
            S_WARN: begin
              state_d      = S_LIVE;
              cnt_d        = LIVE_LOAD;
              shock_done_d = 1'b0;
            end
            S_LIVE: begin
              state_d = S_COOL;
              cnt_d   = COOL_LOAD;
            end
            S_COOL: begin
              state_d = S_IDLE;
              cnt_d   = IDLE_LOAD;
            end
          endcase
        end
      end
    end

    busy_d   = (state_d != S_IDLE);
    status_d = '0;
    case (state_d)
      S_WARN:  status_d[active_d] = 2'b01;
      S_LIVE:  status_d[active_d] = 2'b10;
      S_COOL:  status_d[active_d] = 2'b11;
      S_IDLE:  status_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_IDLE;
      cnt_q         <= IDLE_LOAD;
      last_q        <= IDX_W'(ROPES - 1);
      shock_done_q  <= 1'b0;
      activeRope    <= '0;
      electroStatus <= '0;
      busy          <= 1'b0;
      shockHit      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      shock_done_q  <= shock_done_d;
      activeRope    <= active_d;
      electroStatus <= status_d;
      busy          <= busy_d;
      shockHit      <= shock_d;
    end
  end

endmodule

// File: tb/tb_rope_electro_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rope_electro_scheduler
//
// Directed scenarios for rotation, skipping, full occupancy, shock, disable
// and asynchronous reset, followed by a randomized run compared cycle by cycle
// against a phase-level reference model.
// -----------------------------------------------------------------------------
module tb_rope_electro_scheduler;

  localparam int R  = 6;
  localparam int IW = 3;
  localparam int L_IDLE = 2;
  localparam int L_WARN = 1;
  localparam int L_LIVE = 2;
  localparam int L_COOL = 1;

  logic              clk    = 1'b0;
  logic              resetN = 1'b0;
  logic              sof    = 1'b0;
  logic              en     = 1'b0;
  logic [R-1:0]      coll   = '0;
  logic [R-1:0][1:0] es;
  logic [IW-1:0]     ar;
  logic              busy;
  logic              shock;

  int tests = 0;
  int fails = 0;

  rope_electro_scheduler #(
    .ROPES      (R),
    .IDLE_FRAMES(L_IDLE),
    .WARN_FRAMES(L_WARN),
    .LIVE_FRAMES(L_LIVE),
    .COOL_FRAMES(L_COOL)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (sof),
    .enable         (en),
    .monkeyCollision(coll),
    .electroStatus  (es),
    .activeRope     (ar),
    .busy           (busy),
    .shockHit       (shock)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: phase number (0 idle, 1 warn, 2 live, 3 cool, which is
  // also the status code), frames already spent in the phase, rope history.
  // ---------------------------------------------------------------------------
  int m_phase, m_elapsed, m_last, m_active;
  bit m_sd, m_shock;
  int len [4] = '{L_IDLE, L_WARN, L_LIVE, L_COOL};

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_last = R - 1; m_active = 0;
    m_sd = 0; m_shock = 0;
  endtask

  task automatic model_edge();
    m_shock = 0;
    if (!en) begin
      m_phase = 0; m_elapsed = 0;
      return;
    end
    if (m_phase == 2 && coll[m_active] && !m_sd) begin
      m_shock = 1; m_sd = 1;
    end
    if (sof) begin
      if (m_elapsed < len[m_phase] - 1) begin
        m_elapsed++;
      end else if (m_phase == 0) begin
        int k = -1;
        for (int i = 1; i <= R; i++)
          if (k < 0 && !coll[(m_last + i) % R]) k = (m_last + i) % R;
        if (k >= 0) begin
          m_phase = 1; m_elapsed = 0; m_active = k; m_last = k;
        end
      end else begin
        if (m_phase == 1) m_sd = 0;
        m_phase = (m_phase + 1) % 4;
        m_elapsed = 0;
      end
    end
  endtask

  function automatic logic [R-1:0][1:0] one_hot_status(int rope, int code);
    logic [R-1:0][1:0] v;
    v = '0;
    if (code != 0) v[rope] = 2'(code);
    return v;
  endfunction

  // One clock: advance model with the inputs the DUT samples, settle 1 unit.
  task automatic step();
    @(posedge clk);
    if (!resetN) model_reset();
    else model_edge();
    #1;
  endtask

  // One frame pulse followed by one quiet cycle.
  task automatic pulse();
    sof = 1'b1; step();
    sof = 1'b0; step();
  endtask

  task automatic do_reset();
    resetN = 1'b0; sof = 1'b0; coll = '0; en = 1'b0;
    repeat (2) step();
    resetN = 1'b1; en = 1'b1;
    step();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    tests++; if (es !== '0)   begin fails++; $display("FAIL reset_status: got %b want 0", es); end
    tests++; if (busy !== 0)  begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (ar !== '0)   begin fails++; $display("FAIL reset_rope: got %0d want 0", ar); end
    tests++; if (shock !== 0) begin fails++; $display("FAIL reset_shock: got %b want 0", shock); end
  endtask

  // Six-frame rope cycle: WARN at offset 0, LIVE 1-2, COOL 3, IDLE 4-5;
  // first selection on the second pulse, wrapping after rope 5.
  task automatic test_rotation();
    do_reset();
    for (int p = 1; p <= 38; p++) begin
      int q, rope, code;
      logic [R-1:0][1:0] exp_es;
      pulse();
      rope = 0; code = 0;
      if (p >= 2) begin
        q    = (p - 2) % 6;
        rope = ((p - 2) / 6) % 6;
        code = (q == 0) ? 1 : (q <= 2) ? 2 : (q == 3) ? 3 : 0;
      end
      exp_es = one_hot_status(rope, code);
      tests++;
      if (es !== exp_es || busy !== (code != 0) || (code != 0 && ar !== IW'(rope))) begin
        fails++;
        $display("FAIL rotation_p%0d: es=%b busy=%b rope=%0d, expected es=%b busy=%b rope=%0d",
                 p, es, busy, ar, exp_es, code != 0, rope);
      end
    end
  endtask

  task automatic test_skip();
    do_reset();
    repeat (6) pulse();            // rope 0 cycle done, lastRope=0
    coll = 6'b000010;
    repeat (2) pulse();
    tests++;
    if (ar !== 3'd2 || es !== one_hot_status(2, 1) || busy !== 1'b1) begin
      fails++;
      $display("FAIL skip_busy_rope: rope=%0d es=%b busy=%b, expected rope=2 es=%b busy=1",
               ar, es, busy, one_hot_status(2, 1));
    end
    coll = '0;
  endtask

  task automatic test_all_blocked();
    do_reset();
    coll = '1;
    repeat (2) pulse();
    tests++;
    if (busy !== 0 || es !== '0) begin
      fails++; $display("FAIL all_blocked_expiry: busy=%b es=%b, expected idle", busy, es);
    end
    pulse();
    tests++;
    if (busy !== 0 || es !== '0) begin
      fails++; $display("FAIL all_blocked_retry: busy=%b es=%b, expected idle", busy, es);
    end
    coll = 6'b110111;
    pulse();
    tests++;
    if (ar !== 3'd3 || es !== one_hot_status(3, 1) || busy !== 1'b1) begin
      fails++;
      $display("FAIL blocked_release: rope=%0d es=%b busy=%b, expected rope=3 warn", ar, es, busy);
    end
    coll = '0;
  endtask

  task automatic test_shock();
    do_reset();
    repeat (15) pulse();           // rope 2 entered LIVE on pulse 15
    tests++;
    if (ar !== 3'd2 || es !== one_hot_status(2, 2)) begin
      fails++; $display("FAIL shock_setup: rope=%0d es=%b, expected rope 2 live", ar, es);
    end
    coll = 6'b010000;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (shock !== 1'b0) begin
        fails++; $display("FAIL shock_other_rope_c%0d: got %b want 0", i, shock);
      end
    end
    coll = 6'b000100;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if (shock !== (i == 0)) begin
        fails++; $display("FAIL shock_first_contact_c%0d: got %b want %b", i, shock, i == 0);
      end
    end
    coll = '0;
    step();
    coll = 6'b000100;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (shock !== 1'b0) begin
        fails++; $display("FAIL shock_second_contact_c%0d: got %b want 0", i, shock);
      end
    end
    coll = '0;
  endtask

  task automatic test_disable();
    do_reset();
    repeat (9) pulse();            // rope 1 LIVE
    tests++;
    if (ar !== 3'd1 || es !== one_hot_status(1, 2)) begin
      fails++; $display("FAIL disable_setup: rope=%0d es=%b, expected rope 1 live", ar, es);
    end
    en = 1'b0; sof = 1'b1; coll = 6'b000010;
    step();
    sof = 1'b0;
    tests++;
    if (es !== '0 || busy !== 0 || shock !== 0) begin
      fails++; $display("FAIL disable_blank: es=%b busy=%b shock=%b, expected all 0", es, busy, shock);
    end
    coll = '0;
    pulse();
    tests++;
    if (busy !== 0 || es !== '0) begin
      fails++; $display("FAIL disable_hold: busy=%b es=%b, expected idle", busy, es);
    end
    en = 1'b1;
    pulse();
    tests++;
    if (busy !== 0) begin
      fails++; $display("FAIL reenable_first: busy=%b want 0", busy);
    end
    pulse();
    tests++;
    if (ar !== 3'd2 || es !== one_hot_status(2, 1) || busy !== 1'b1) begin
      fails++; $display("FAIL reenable_pick: rope=%0d es=%b busy=%b, expected rope 2 warn", ar, es, busy);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (8) pulse();            // rope 1 WARN
    tests++;
    if (ar !== 3'd1 || es !== one_hot_status(1, 1)) begin
      fails++; $display("FAIL areset_setup: rope=%0d es=%b, expected rope 1 warn", ar, es);
    end
    #3 resetN = 1'b0;
    #1;
    tests++;
    if (es !== '0 || busy !== 0 || ar !== '0 || shock !== 0) begin
      fails++;
      $display("FAIL areset_immediate: es=%b busy=%b rope=%0d shock=%b, expected all 0", es, busy, ar, shock);
    end
    step();
    resetN = 1'b1;
    step();
    repeat (2) pulse();
    tests++;
    if (ar !== 3'd0 || es !== one_hot_status(0, 1) || busy !== 1'b1) begin
      fails++; $display("FAIL areset_restart: rope=%0d es=%b busy=%b, expected rope 0 warn", ar, es, busy);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [R-1:0][1:0] exp_es;
      sof    = ($urandom_range(2) == 0);
      en     = ($urandom_range(15) != 0);
      coll   = ($urandom_range(39) == 0) ? '1 : R'($urandom & $urandom);
      resetN = ($urandom_range(299) != 0);
      step();
      exp_es = one_hot_status(m_active, m_phase);
      tests++;
      if (es !== exp_es || busy !== (m_phase != 0) || ar !== IW'(m_active) || shock !== m_shock) begin
        fails++;
        $display("FAIL random_c%0d: es=%b busy=%b rope=%0d shock=%b, expected es=%b busy=%b rope=%0d shock=%b",
                 c, es, busy, ar, shock, exp_es, m_phase != 0, m_active, m_shock);
      end
    end
    resetN = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_skip();
    test_all_blocked();
    test_shock();
    test_disable();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
